// File: rtl/sync_ram_clr_if.sv
// rtl/sync_ram_clr_if.sv - request/response bundle for sync_ram_clr (SYNC_RAM_CLR_PARITY_EN adds inj_par_err)
interface sync_ram_clr_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  clr_start;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [BE_WIDTH-1:0]   req_be;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  busy;
`ifdef SYNC_RAM_CLR_PARITY_EN
    logic                  inj_par_err;

    modport master (
        output clr_start, req_valid, req_wr, req_addr, req_wdata, req_be, inj_par_err,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
    modport slave (
        input  clr_start, req_valid, req_wr, req_addr, req_wdata, req_be, inj_par_err,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
`else
    modport master (
        output clr_start, req_valid, req_wr, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
    modport slave (
        input  clr_start, req_valid, req_wr, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
`endif
endinterface

// File: rtl/sync_ram_clr.sv
// rtl/sync_ram_clr.sv - single-port byte-masked RAM with hardware clear sweep (optional SYNC_RAM_CLR_PARITY_EN)
module sync_ram_clr #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic           clk,
    input  logic           reset,
    sync_ram_clr_if.slave  bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic                  in_range;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_err;

    assign in_range = ({1'b0, bus.req_addr} < DEPTH_L);
    assign wr_acc   = bus.req_valid && bus.req_ready && bus.req_wr;
    assign rd_acc   = bus.req_valid && bus.req_ready && !bus.req_wr;
    assign rd_word  = in_range ? mem[bus.req_addr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_CLEAR;
        else       state_q <= state_d;
    end

    // clr_start is only honoured from IDLE; a request accepted on the same edge still completes
    always_comb begin
        state_d       = state_q;
        bus.busy      = 1'b0;
        bus.req_ready = 1'b0;
        case (state_q)
            S_CLEAR: begin
                bus.busy = 1'b1;
                if (clr_ptr == LAST_PTR) state_d = S_IDLE;
            end
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.clr_start) state_d = S_CLEAR;
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_ptr <= '0;
        end else if (state_q == S_CLEAR) begin
            clr_ptr <= (clr_ptr == LAST_PTR) ? '0 : clr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (wr_acc && in_range) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (bus.req_be[i]) mem[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
            end
        end
    end

`ifdef SYNC_RAM_CLR_PARITY_EN
    logic [BE_WIDTH-1:0] par_mem [0:DEPTH-1];

    function automatic logic [BE_WIDTH-1:0] byte_par(input logic [DATA_WIDTH-1:0] d);
        logic [BE_WIDTH-1:0] p;
        for (int i = 0; i < BE_WIDTH; i++) p[i] = ^d[8*i +: 8];
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            par_mem[clr_ptr] <= '0;
        end else if (wr_acc && in_range) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (bus.req_be[i]) par_mem[bus.req_addr][i] <= (^bus.req_wdata[8*i +: 8]) ^ bus.inj_par_err;
            end
        end
    end

    assign rd_err = in_range ? |(par_mem[bus.req_addr] ^ byte_par(mem[bus.req_addr])) : 1'b0;
`else
    assign rd_err = 1'b0;
`endif

    // rsp_rdata/rsp_err only move on an accepted read, so they hold between responses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.rsp_valid <= rd_acc;
            if (rd_acc) begin
                bus.rsp_rdata <= rd_word;
                bus.rsp_err   <= rd_err;
            end
        end
    end
endmodule

// File: tb/tb_sync_ram_clr.sv
// tb/tb_sync_ram_clr.sv - self-checking bench for sync_ram_clr against an array reference model
module tb_sync_ram_clr;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sync_ram_clr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) ia ();
    sync_ram_clr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) ib ();

    sync_ram_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1024)) dut_a (
        .clk(clk), .reset(reset), .bus(ia.slave));
    sync_ram_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1000)) dut_b (
        .clk(clk), .reset(reset), .bus(ib.slave));

    int passed = 0;
    int total  = 0;
    logic [31:0] mdl_a [0:1023];
    logic [31:0] mdl_b [0:999];
    logic [31:0] exp_d;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input bit v, input bit wr, input logic [9:0] addr,
                           input logic [31:0] d, input logic [3:0] be, input bit clr);
        ia.req_valid = v;  ia.req_wr = wr;  ia.req_addr = addr;
        ia.req_wdata = d;  ia.req_be = be;  ia.clr_start = clr;
    endtask

    task automatic a_write(input logic [9:0] addr, input logic [31:0] d, input logic [3:0] be);
        a_drive(1'b1, 1'b1, addr, d, be, 1'b0);
        step();
        for (int i = 0; i < 4; i++) if (be[i]) mdl_a[addr][8*i +: 8] = d[8*i +: 8];
        a_drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic a_read(input string tag, input logic [9:0] addr);
        a_drive(1'b1, 1'b0, addr, '0, '0, 1'b0);
        step();
        a_drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        exp_d = mdl_a[addr];
        check({tag, "_valid"}, ia.rsp_valid, 1);
        check({tag, "_rdata"}, ia.rsp_rdata, exp_d);
        check({tag, "_err"},   ia.rsp_err, 0);
    endtask

    task automatic b_drive(input bit v, input bit wr, input logic [9:0] addr, input logic [31:0] d);
        ib.req_valid = v;  ib.req_wr = wr;  ib.req_addr = addr;
        ib.req_wdata = d;  ib.req_be = 4'hF;  ib.clr_start = 1'b0;
    endtask

    task automatic count_sweep(input string tag, input int exp_a, input int exp_b, input int pulse_at);
        int n = 0;
        int nb = 0;
        while (ia.busy && n < 3000) begin
            if (ib.busy) nb++;
            ia.clr_start = (n == pulse_at);
            step();
            n++;
        end
        ia.clr_start = 1'b0;
        check({tag, "_busy_cycles"}, n, exp_a);
        if (exp_b >= 0) check({tag, "_busy_cycles_b"}, nb, exp_b);
        check({tag, "_ready"}, ia.req_ready, 1);
        for (int i = 0; i < 1024; i++) mdl_a[i] = '0;
    endtask

    initial begin
        bit v, wr;
        logic [9:0]  addr;
        logic [31:0] d;
        logic [3:0]  be;

        a_drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        b_drive(1'b0, 1'b0, '0, '0);
`ifdef SYNC_RAM_CLR_PARITY_EN
        ia.inj_par_err = 1'b0;
        ib.inj_par_err = 1'b0;
`endif
        for (int i = 0; i < 1024; i++) mdl_a[i] = '0;
        for (int i = 0; i < 1000; i++) mdl_b[i] = '0;

        #2 reset = 1'b1;
        #1;
        check("rst_busy", ia.busy, 1);
        check("rst_ready", ia.req_ready, 0);
        check("rst_valid", ia.rsp_valid, 0);
        check("rst_rdata", ia.rsp_rdata, 0);
        check("rst_err", ia.rsp_err, 0);
        step();
        step();
        reset = 1'b0;
        count_sweep("init", 1024, 1000, -1);

        a_read("rd5", 10'd5);
        step();
        check("rd5_pulse_end", ia.rsp_valid, 0);
        check("rd5_hold", ia.rsp_rdata, exp_d);

        a_write(10'd3, 32'hDEADBEEF, 4'hF);
        a_read("rd3", 10'd3);
        check("rd3_const", ia.rsp_rdata, 32'hDEADBEEF);

        a_write(10'd7, 32'hFFFFFFFF, 4'hF);
        a_write(10'd7, 32'h11223344, 4'b0101);
        a_read("rd7", 10'd7);
        check("rd7_const", ia.rsp_rdata, 32'hFF22FF44);

        a_write(10'd8, 32'h0BADF00D, 4'h0);
        a_read("rd8_be0", 10'd8);

        for (int k = 0; k < 300; k++) begin
            v    = ($urandom % 4) != 0;
            wr   = $urandom % 2;
            addr = 10'($urandom % 32);
            d    = $urandom;
            be   = 4'($urandom);
            a_drive(v, wr, addr, d, be, 1'b0);
            step();
            if (v && wr) for (int i = 0; i < 4; i++) if (be[i]) mdl_a[addr][8*i +: 8] = d[8*i +: 8];
            if (v && !wr) exp_d = mdl_a[addr];
            check("rnd_valid", ia.rsp_valid, (v && !wr));
            check("rnd_rdata", ia.rsp_rdata, exp_d);
        end
        a_drive(1'b0, 1'b0, '0, '0, '0, 1'b0);

        a_write(10'd40, 32'hCAFE0001, 4'hF);
        a_drive(1'b1, 1'b0, 10'd40, '0, '0, 1'b0);
        step();
        a_drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        check("midrd_valid", ia.rsp_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("midrd_drop_valid", ia.rsp_valid, 0);
        check("midrd_rdata_rst", ia.rsp_rdata, 0);
        check("midrd_busy", ia.busy, 1);
        step();
        reset = 1'b0;
        count_sweep("rerst", 1024, 1000, -1);
        a_read("rerst_rd40", 10'd40);

        a_write(10'd9, 32'hA5A5A5A5, 4'hF);
        a_drive(1'b1, 1'b0, 10'd9, '0, '0, 1'b1);
        step();
        a_drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        check("clr_rd_valid", ia.rsp_valid, 1);
        check("clr_rd_rdata", ia.rsp_rdata, 32'hA5A5A5A5);
        check("clr_busy", ia.busy, 1);
        check("clr_ready", ia.req_ready, 0);
        count_sweep("clr", 1024, -1, 10);
        a_read("clr_rd9", 10'd9);
        a_read("clr_rd3", 10'd3);

        b_drive(1'b1, 1'b1, 10'd0, 32'h12345678);   step();
        b_drive(1'b1, 1'b1, 10'd999, 32'h9ABCDEF0); step();
        b_drive(1'b1, 1'b1, 10'd1000, 32'hFFFFFFFF); step();
        b_drive(1'b1, 1'b1, 10'd1023, 32'hFFFFFFFF); step();
        mdl_b[0]   = 32'h12345678;
        mdl_b[999] = 32'h9ABCDEF0;
        b_drive(1'b1, 1'b0, 10'd1000, '0); step();
        b_drive(1'b0, 1'b0, '0, '0);
        check("oor_rd_valid", ib.rsp_valid, 1);
        check("oor_rd_rdata", ib.rsp_rdata, 0);
        for (int i = 0; i < 1000; i++) begin
            b_drive(1'b1, 1'b0, 10'(i), '0);
            step();
            check("b_sweep_valid", ib.rsp_valid, 1);
            check("b_sweep_rdata", ib.rsp_rdata, mdl_b[i]);
        end
        b_drive(1'b0, 1'b0, '0, '0);

`ifdef SYNC_RAM_CLR_PARITY_EN
        ia.inj_par_err = 1'b1;
        a_write(10'd2, 32'h5A3C0F81, 4'hF);
        ia.inj_par_err = 1'b0;
        a_drive(1'b1, 1'b0, 10'd2, '0, '0, 1'b0);
        step();
        a_drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        check("par_inj_valid", ia.rsp_valid, 1);
        check("par_inj_err", ia.rsp_err, 1);
        a_write(10'd2, 32'h5A3C0F81, 4'hF);
        a_read("par_clean", 10'd2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
